// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: result-source select, access sizes,
// load funct3 values and the access FSM states.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Access size lives in funct3[1:0] for both loads and stores.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } access_size_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } mem_state_e;

endpackage

// File: rtl/memory_stage_if.sv
// Handshaked data-memory port: the stage drives request/address/data/enables,
// the memory returns the read word and an accept/complete ack.
interface memory_stage_if #(
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/memory_stage_load_store_align.sv
// Byte-lane steering for stores, lane extraction plus sign/zero extension for
// loads, and natural-alignment checking. Purely combinational.
module memory_stage_load_store_align
  import memory_stage_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [2:0]         funct3_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [D_WIDTH-1:0] store_data_i,
  input  logic [D_WIDTH-1:0] read_word_i,
  output logic [3:0]         be_o,
  output logic [D_WIDTH-1:0] wdata_o,
  output logic [D_WIDTH-1:0] load_data_o,
  output logic               mis_o
);

  logic [D_WIDTH-1:0] lane_shifted;

  assign lane_shifted = read_word_i >> {addr_lo_i, 3'b000};

  // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    mis_o   = 1'b0;
    case (funct3_i[1:0])
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
        mis_o   = addr_lo_i[0];
      end
      default: mis_o = (funct3_i[1:0] == SZ_WORD) && (addr_lo_i != 2'b00);
    endcase
  end

  // Reserved funct3 encodings fall back to a full-word load.
  always_comb begin
    load_data_o = read_word_i;
    case (funct3_i)
      F3_LB:   load_data_o = {{(D_WIDTH-8){lane_shifted[7]}}, lane_shifted[7:0]};
      F3_LBU:  load_data_o = {{(D_WIDTH-8){1'b0}}, lane_shifted[7:0]};
      F3_LH:   load_data_o = {{(D_WIDTH-16){lane_shifted[15]}}, lane_shifted[15:0]};
      F3_LHU:  load_data_o = {{(D_WIDTH-16){1'b0}}, lane_shifted[15:0]};
      default: load_data_o = read_word_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM and MEM/WB registers, data-memory handshake,
// upstream stall while an access waits, and M-stage forwarding values.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_write_e_i,
  input  logic [1:0]         result_src_e_i,
  input  logic               mem_write_e_i,
  input  logic [D_WIDTH-1:0] alu_result_e_i,
  input  logic [D_WIDTH-1:0] write_data_e_i,
  input  logic [4:0]         rd_e_i,
  input  logic [D_WIDTH-1:0] pc_plus_4e_i,
  input  logic [2:0]         funct3_e_i,
  output logic               stall_m_o,
  memory_stage_if.master     dmem,
  output logic               reg_write_m_o,
  output logic [4:0]         rd_m_o,
  output logic [D_WIDTH-1:0] alu_result_m_o,
  output logic               misalign_o,
  output logic               reg_write_w_o,
  output logic [1:0]         result_src_w_o,
  output logic [4:0]         rd_w_o,
  output logic [D_WIDTH-1:0] alu_result_w_o,
  output logic [D_WIDTH-1:0] read_data_w_o,
  output logic [D_WIDTH-1:0] pc_plus_4w_o
);

  logic               reg_write_m_q, mem_write_m_q;
  logic [1:0]         result_src_m_q;
  logic [D_WIDTH-1:0] alu_result_m_q, write_data_m_q, pc_plus_4_m_q;
  logic [4:0]         rd_m_q;
  logic [2:0]         funct3_m_q;

  logic               reg_write_w_q;
  logic [1:0]         result_src_w_q;
  logic [4:0]         rd_w_q;
  logic [D_WIDTH-1:0] alu_result_w_q, read_data_w_q, pc_plus_4_w_q;

  logic               is_load, is_store, mem_op, mis_raw, mis, req;
  logic [3:0]         lane_be;
  logic [D_WIDTH-1:0] lane_wdata, load_data;
  mem_state_e         state_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      mem_write_m_q  <= 1'b0;
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      rd_m_q         <= '0;
      pc_plus_4_m_q  <= '0;
      funct3_m_q     <= '0;
    end else if (!stall_m_o) begin
      reg_write_m_q  <= reg_write_e_i;
      result_src_m_q <= result_src_e_i;
      mem_write_m_q  <= mem_write_e_i;
      alu_result_m_q <= alu_result_e_i;
      write_data_m_q <= write_data_e_i;
      rd_m_q         <= rd_e_i;
      pc_plus_4_m_q  <= pc_plus_4e_i;
      funct3_m_q     <= funct3_e_i;
    end
  end

  assign is_load  = (result_src_m_q == RES_MEM) && !mem_write_m_q;
  assign is_store = mem_write_m_q;
  assign mem_op   = is_load || is_store;

  memory_stage_load_store_align #(.D_WIDTH(D_WIDTH)) u_align (
    .funct3_i     (funct3_m_q),
    .addr_lo_i    (alu_result_m_q[1:0]),
    .store_data_i (write_data_m_q),
    .read_word_i  (dmem.rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (load_data),
    .mis_o        (mis_raw)
  );

  // The request is held stable through a wait because the stall freezes EX/MEM.
  assign mis        = mem_op && mis_raw;
  assign req        = mem_op && !mis;
  assign stall_m_o  = req && !dmem.ack;
  assign misalign_o = mis;

  assign dmem.req   = req;
  assign dmem.we    = req && is_store;
  assign dmem.addr  = req ? {alu_result_m_q[D_WIDTH-1:2], 2'b00} : '0;
  assign dmem.wdata = (req && is_store) ? lane_wdata : '0;
  assign dmem.be    = req ? lane_be : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (req && !dmem.ack) state_q <= S_WAIT;
        S_WAIT:  if (dmem.ack) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stalled or misaligned accesses retire as a fully cleared bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      rd_w_q         <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      pc_plus_4_w_q  <= '0;
    end else if (stall_m_o || mis) begin
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      rd_w_q         <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      pc_plus_4_w_q  <= '0;
    end else begin
      reg_write_w_q  <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
      rd_w_q         <= rd_m_q;
      alu_result_w_q <= alu_result_m_q;
      read_data_w_q  <= is_load ? load_data : '0;
      pc_plus_4_w_q  <= pc_plus_4_m_q;
    end
  end

  assign reg_write_m_o  = reg_write_m_q;
  assign rd_m_o         = rd_m_q;
  assign alu_result_m_o = alu_result_m_q;

  assign reg_write_w_o  = reg_write_w_q;
  assign result_src_w_o = result_src_w_q;
  assign rd_w_o         = rd_w_q;
  assign alu_result_w_o = alu_result_w_q;
  assign read_data_w_o  = read_data_w_q;
  assign pc_plus_4w_o   = pc_plus_4_w_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a table of single-instruction vectors with
// zero-wait ack, plus hand-written wait-state, back-to-back and reset sequences.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_e, mem_write_e;
  logic [1:0]  result_src_e;
  logic [31:0] alu_result_e, write_data_e, pc_plus_4e;
  logic [4:0]  rd_e;
  logic [2:0]  funct3_e;
  logic        stall_m, reg_write_m, misalign, reg_write_w;
  logic [4:0]  rd_m, rd_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_m, alu_result_w, read_data_w, pc_plus_4w;

  int tests_run = 0;
  int tests_failed = 0;

  memory_stage_if #(.DW(32)) dmem_bus ();

  memory_stage #(.D_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .reg_write_e_i  (reg_write_e),
    .result_src_e_i (result_src_e),
    .mem_write_e_i  (mem_write_e),
    .alu_result_e_i (alu_result_e),
    .write_data_e_i (write_data_e),
    .rd_e_i         (rd_e),
    .pc_plus_4e_i   (pc_plus_4e),
    .funct3_e_i     (funct3_e),
    .stall_m_o      (stall_m),
    .dmem           (dmem_bus),
    .reg_write_m_o  (reg_write_m),
    .rd_m_o         (rd_m),
    .alu_result_m_o (alu_result_m),
    .misalign_o     (misalign),
    .reg_write_w_o  (reg_write_w),
    .result_src_w_o (result_src_w),
    .rd_w_o         (rd_w),
    .alu_result_w_o (alu_result_w),
    .read_data_w_o  (read_data_w),
    .pc_plus_4w_o   (pc_plus_4w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        mw;
    logic [1:0]  rs;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_daddr;
    logic [31:0] exp_dwdata;
    logic        exp_mis;
    logic        exp_rw_w;
    logic [31:0] exp_rdw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [2:0] f3, input logic mw, input logic [1:0] rs, input logic rw,
    input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
    input logic [31:0] rdata, input logic req, input logic we, input logic [3:0] be,
    input logic [31:0] daddr, input logic [31:0] dwdata, input logic mis,
    input logic rw_w, input logic [31:0] rdw);
    vec_t v;
    v.f3 = f3; v.mw = mw; v.rs = rs; v.rw = rw; v.addr = addr; v.wd = wd;
    v.rd = rd; v.rdata = rdata; v.exp_req = req; v.exp_we = we; v.exp_be = be;
    v.exp_daddr = daddr; v.exp_dwdata = dwdata; v.exp_mis = mis;
    v.exp_rw_w = rw_w; v.exp_rdw = rdw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input vec_t v);
    reg_write_e  = v.rw;
    result_src_e = v.rs;
    mem_write_e  = v.mw;
    alu_result_e = v.addr;
    write_data_e = v.wd;
    rd_e         = v.rd;
    pc_plus_4e   = v.addr + 32'd4;
    funct3_e     = v.f3;
  endtask

  task automatic drive_nop();
    reg_write_e = 1'b0; result_src_e = 2'b00; mem_write_e = 1'b0;
    alu_result_e = '0; write_data_e = '0; rd_e = '0; pc_plus_4e = '0; funct3_e = '0;
  endtask

  vec_t v, op_sb, op_alu, op_lw;
  vec_t prog[3];
  int   stall_cnt, ack_cnt, wait_cnt, wb_cnt, ptr;
  logic adv;
  logic [31:0] ack_addr[4];
  logic        ack_we[4];
  logic [31:0] ack_wdata[4];
  logic [4:0]  wb_rd[4];
  logic [31:0] wb_val[4];

  initial begin
    rst = 1'b1;
    drive_nop();
    dmem_bus.ack = 1'b0;
    dmem_bus.rdata = '0;

    //            f3      mw  rs     rw  addr          wd            rd     rdata         req we be       daddr         dwdata        mis rw_w rdw
    vecs.push_back(mk(3'b010, 1, 2'b00, 0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  32'h0,        1, 1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0));
    vecs.push_back(mk(3'b000, 1, 2'b00, 0, 32'h0000_0103, 32'h0000_00A5, 5'd0,  32'h0,        1, 1, 4'b1000, 32'h0000_0100, 32'hA5A5_A5A5, 0, 0, 32'h0));
    vecs.push_back(mk(3'b001, 1, 2'b00, 0, 32'h0000_0102, 32'h1234_BEEF, 5'd0,  32'h0,        1, 1, 4'b1100, 32'h0000_0100, 32'hBEEF_BEEF, 0, 0, 32'h0));
    vecs.push_back(mk(3'b000, 0, 2'b01, 1, 32'h0000_0202, 32'h0,         5'd5,  32'h0080_0000, 1, 0, 4'b0100, 32'h0000_0200, 32'h0,         0, 1, 32'hFFFF_FF80));
    vecs.push_back(mk(3'b100, 0, 2'b01, 1, 32'h0000_0202, 32'h0,         5'd6,  32'h0080_0000, 1, 0, 4'b0100, 32'h0000_0200, 32'h0,         0, 1, 32'h0000_0080));
    vecs.push_back(mk(3'b101, 0, 2'b01, 1, 32'h0000_0202, 32'h0,         5'd7,  32'hBEEF_0000, 1, 0, 4'b1100, 32'h0000_0200, 32'h0,         0, 1, 32'h0000_BEEF));
    vecs.push_back(mk(3'b001, 0, 2'b01, 1, 32'h0000_0200, 32'h0,         5'd8,  32'h0000_8001, 1, 0, 4'b0011, 32'h0000_0200, 32'h0,         0, 1, 32'hFFFF_8001));
    vecs.push_back(mk(3'b000, 0, 2'b01, 1, 32'h0000_0201, 32'h0,         5'd9,  32'h0000_7F00, 1, 0, 4'b0010, 32'h0000_0200, 32'h0,         0, 1, 32'h0000_007F));
    vecs.push_back(mk(3'b010, 0, 2'b01, 1, 32'h0000_0204, 32'h0,         5'd10, 32'hCAFE_F00D, 1, 0, 4'b1111, 32'h0000_0204, 32'h0,         0, 1, 32'hCAFE_F00D));
    vecs.push_back(mk(3'b011, 0, 2'b01, 1, 32'h0000_0208, 32'h0,         5'd11, 32'h1122_3344, 1, 0, 4'b1111, 32'h0000_0208, 32'h0,         0, 1, 32'h1122_3344));
    vecs.push_back(mk(3'b010, 0, 2'b01, 1, 32'h0000_0102, 32'h0,         5'd12, 32'h5555_5555, 0, 0, 4'b0000, 32'h0,         32'h0,         1, 0, 32'h0));
    vecs.push_back(mk(3'b001, 1, 2'b00, 0, 32'h0000_0101, 32'h0000_1234, 5'd0,  32'h0,        0, 0, 4'b0000, 32'h0,         32'h0,         1, 0, 32'h0));
    vecs.push_back(mk(3'b000, 0, 2'b00, 1, 32'h1234_5678, 32'h0,         5'd13, 32'h0,        0, 0, 4'b0000, 32'h0,         32'h0,         0, 1, 32'h0));
    vecs.push_back(mk(3'b000, 0, 2'b10, 1, 32'h0000_1000, 32'h0,         5'd1,  32'h0,        0, 0, 4'b0000, 32'h0,         32'h0,         0, 1, 32'h0));

    // Reset state
    #12;
    check("rst_req", dmem_bus.req, 1'b0);
    check("rst_stall", stall_m, 1'b0);
    check("rst_rw_w", reg_write_w, 1'b0);
    check("rst_alu_w", alu_result_w, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors, ack held high so an ack with no request must be ignored
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive_ex(v);
      @(posedge clk); #1;
      drive_nop();
      dmem_bus.ack = 1'b1;
      dmem_bus.rdata = v.rdata;
      #1;
      check($sformatf("v%0d_req", i), dmem_bus.req, v.exp_req);
      check($sformatf("v%0d_we", i), dmem_bus.we, v.exp_we);
      check($sformatf("v%0d_be", i), dmem_bus.be, v.exp_be);
      check($sformatf("v%0d_daddr", i), dmem_bus.addr, v.exp_daddr);
      check($sformatf("v%0d_dwdata", i), dmem_bus.wdata, v.exp_dwdata);
      check($sformatf("v%0d_mis", i), misalign, v.exp_mis);
      check($sformatf("v%0d_stall", i), stall_m, 1'b0);
      check($sformatf("v%0d_rw_m", i), reg_write_m, v.rw);
      check($sformatf("v%0d_rd_m", i), rd_m, v.rd);
      @(posedge clk); #1;
      dmem_bus.ack = 1'b0;
      check($sformatf("v%0d_mis_pulse", i), misalign, 1'b0);
      check($sformatf("v%0d_rw_w", i), reg_write_w, v.exp_rw_w);
      if (v.exp_rw_w) begin
        check($sformatf("v%0d_rd_w", i), rd_w, v.rd);
        check($sformatf("v%0d_alu_w", i), alu_result_w, v.addr);
        check($sformatf("v%0d_src_w", i), result_src_w, v.rs);
        check($sformatf("v%0d_pc4_w", i), pc_plus_4w, v.addr + 32'd4);
        if (v.rs == 2'b01) check($sformatf("v%0d_rdata_w", i), read_data_w, v.exp_rdw);
      end
    end

    // SB with three wait cycles; the following ALU op must be held in EX
    op_sb  = mk(3'b000, 1, 2'b00, 0, 32'h0000_0103, 32'h0000_00A5, 5'd0, 32'h0, 1, 1, 4'b1000, 32'h100, 32'hA5A5_A5A5, 0, 0, 32'h0);
    op_alu = mk(3'b000, 0, 2'b00, 1, 32'h0000_0055, 32'h0, 5'd9, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 1, 32'h0);
    drive_ex(op_sb);
    @(posedge clk); #1;
    drive_ex(op_alu);
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      dmem_bus.ack = (c == 3);
      #1;
      if (stall_m) stall_cnt++;
      check($sformatf("sb_req_c%0d", c), dmem_bus.req, 1'b1);
      check($sformatf("sb_be_c%0d", c), dmem_bus.be, 4'b1000);
      check($sformatf("sb_wdata_c%0d", c), dmem_bus.wdata, 32'hA5A5_A5A5);
      check($sformatf("sb_addr_c%0d", c), dmem_bus.addr, 32'h0000_0100);
      check($sformatf("sb_hold_m_c%0d", c), alu_result_m, 32'h0000_0103);
      if (c > 0) check($sformatf("sb_bubble_w_c%0d", c), reg_write_w, 1'b0);
      @(posedge clk); #1;
    end
    dmem_bus.ack = 1'b0;
    drive_nop();
    check("sb_stall_cycles", stall_cnt, 32'd3);
    check("sb_next_alu_m", alu_result_m, 32'h0000_0055);
    check("sb_next_rd_m", rd_m, 5'd9);
    check("sb_next_req", dmem_bus.req, 1'b0);
    check("sb_store_w", reg_write_w, 1'b0);
    @(posedge clk); #1;
    check("sb_next_rw_w", reg_write_w, 1'b1);
    check("sb_next_alu_w", alu_result_w, 32'h0000_0055);
    check("sb_next_rd_w", rd_w, 5'd9);

    // Back-to-back LW, SW, ALU with a one-cycle ack delay each
    prog[0] = mk(3'b010, 0, 2'b01, 1, 32'h0000_0300, 32'h0, 5'd10, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0);
    prog[1] = mk(3'b010, 1, 2'b00, 0, 32'h0000_0304, 32'h0BAD_F00D, 5'd0, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0);
    prog[2] = mk(3'b000, 0, 2'b00, 1, 32'h0000_0077, 32'h0, 5'd11, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0);
    ptr = 0; ack_cnt = 0; wait_cnt = 0; wb_cnt = 0; stall_cnt = 0;
    dmem_bus.rdata = 32'hA1B2_C3D4;
    drive_ex(prog[0]);
    @(posedge clk); #1;
    ptr = 1;
    drive_ex(prog[1]);
    for (int cyc = 0; cyc < 12; cyc++) begin
      dmem_bus.ack = dmem_bus.req && (wait_cnt == 1);
      #1;
      if (dmem_bus.req && dmem_bus.ack) begin
        if (ack_cnt < 4) begin
          ack_addr[ack_cnt] = dmem_bus.addr;
          ack_we[ack_cnt] = dmem_bus.we;
          ack_wdata[ack_cnt] = dmem_bus.wdata;
        end
        ack_cnt++;
      end
      if (stall_m) stall_cnt++;
      if (reg_write_w) begin
        if (wb_cnt < 4) begin
          wb_rd[wb_cnt] = rd_w;
          wb_val[wb_cnt] = (result_src_w == 2'b01) ? read_data_w : alu_result_w;
        end
        wb_cnt++;
      end
      if (alu_result_m == 32'h0000_0300) begin
        check($sformatf("b2b_fwd_rw_m_c%0d", cyc), reg_write_m, 1'b1);
        check($sformatf("b2b_fwd_rd_m_c%0d", cyc), rd_m, 5'd10);
      end
      wait_cnt = (dmem_bus.req && !dmem_bus.ack) ? wait_cnt + 1 : 0;
      adv = !stall_m;
      @(posedge clk); #1;
      if (adv) begin
        ptr++;
        if (ptr < 3) drive_ex(prog[ptr]);
        else drive_nop();
      end
    end
    dmem_bus.ack = 1'b0;
    check("b2b_ack_count", ack_cnt, 32'd2);
    check("b2b_stall_cycles", stall_cnt, 32'd2);
    check("b2b_ack0_addr", ack_addr[0], 32'h0000_0300);
    check("b2b_ack0_we", ack_we[0], 1'b0);
    check("b2b_ack1_addr", ack_addr[1], 32'h0000_0304);
    check("b2b_ack1_we", ack_we[1], 1'b1);
    check("b2b_ack1_wdata", ack_wdata[1], 32'h0BAD_F00D);
    check("b2b_wb_count", wb_cnt, 32'd2);
    check("b2b_wb0_rd", wb_rd[0], 5'd10);
    check("b2b_wb0_val", wb_val[0], 32'hA1B2_C3D4);
    check("b2b_wb1_rd", wb_rd[1], 5'd11);
    check("b2b_wb1_val", wb_val[1], 32'h0000_0077);

    // Reset asserted while a load waits for its ack
    op_lw = mk(3'b010, 0, 2'b01, 1, 32'h0000_0400, 32'h0, 5'd3, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0);
    drive_ex(op_lw);
    @(posedge clk); #1;
    drive_nop();
    check("rstw_req_before", dmem_bus.req, 1'b1);
    check("rstw_stall_before", stall_m, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_req_drop", dmem_bus.req, 1'b0);
    check("rstw_stall_drop", stall_m, 1'b0);
    check("rstw_mis_drop", misalign, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstw_rw_w", reg_write_w, 1'b0);
    check("rstw_src_w", result_src_w, 2'b00);
    check("rstw_rd_w", rd_w, 5'd0);
    check("rstw_alu_w", alu_result_w, 32'h0);
    check("rstw_rdata_w", read_data_w, 32'h0);
    check("rstw_pc4_w", pc_plus_4w, 32'h0);
    check("rstw_req_after", dmem_bus.req, 1'b0);

    // After reset a fresh zero-wait load completes without a stall
    dmem_bus.rdata = 32'h0102_0304;
    drive_ex(op_lw);
    @(posedge clk); #1;
    drive_nop();
    dmem_bus.ack = 1'b1;
    #1;
    check("post_rst_req", dmem_bus.req, 1'b1);
    check("post_rst_stall", stall_m, 1'b0);
    @(posedge clk); #1;
    dmem_bus.ack = 1'b0;
    check("post_rst_rw_w", reg_write_w, 1'b1);
    check("post_rst_rdata_w", read_data_w, 32'h0102_0304);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
